// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: data-side bus target behind the cpu data port.
//
// Decodes ADDR[31:28]. 4'h0 selects the on-chip data RAM, indexed by
// ADDR[DEPTH_LOG2-1:0], so the upper index bits alias. 4'hF selects the
// peripheral page at offset ADDR[3:0]. Every other region is unmapped.
// Peripheral page:
//   0 GPIO_OUT (RW)
//   1 GPIO_IN  (RO, writes ignored)
//   2 TMR_CNT, 3 TMR_CMP, 4 TMR_CTRL {irq_en, reload, en}
//   5 TMR_STAT (bit0 match flag, write 1 to clear)
// Unmapped accesses pulse bus_err for one cycle. Unmapped reads return
// 32'hDEAD_BEEF.
//
// Optional feature macro: DATA_BUS_TIMER_EN.
//   Defined:   the timer is built.
//   Undefined: offsets 2..5 are unmapped and irq is tied to 0.
//
// Ports:
//   CLK, reset      rising-edge clock, asynchronous active-high reset
//   CS, WE          access strobe and write qualifier, sampled on CLK
//   ADDR            word address
//   Data_BUS_WRITE  write data
//   Data_BUS_READ   registered read data; it only changes on sampled reads
//   gpio_in         asynchronous inputs, passed through a 2-flop synchronizer
//   gpio_out        GPIO output register
//   irq             timer match flag & irq enable (level)
//   bus_err         one-cycle pulse for an unmapped access

module data_bus_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned GPIO_W     = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              CS,
    input  logic              WE,
    input  logic [31:0]       ADDR,
    input  logic [31:0]       Data_BUS_WRITE,
    output logic [31:0]       Data_BUS_READ,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq,
    output logic              bus_err
);

    localparam int unsigned Depth        = 2 ** DEPTH_LOG2;
    localparam logic [31:0] UnmappedData = 32'hDEAD_BEEF;

    localparam logic [3:0] OffGpioOut = 4'd0;
    localparam logic [3:0] OffGpioIn  = 4'd1;
`ifdef DATA_BUS_TIMER_EN
    localparam logic [3:0] OffTmrCnt  = 4'd2;
    localparam logic [3:0] OffTmrCmp  = 4'd3;
    localparam logic [3:0] OffTmrCtrl = 4'd4;
    localparam logic [3:0] OffTmrStat = 4'd5;
`endif

    // Address decode
    logic                  is_ram;
    logic                  is_periph;
    logic [3:0]            offset;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic                  rd_en;
    logic                  wr_en;
    logic                  unused_addr;

    assign is_ram    = (ADDR[31:28] == 4'h0);
    assign is_periph = (ADDR[31:28] == 4'hF);
    assign offset    = ADDR[3:0];
    assign ram_idx   = ADDR[DEPTH_LOG2-1:0];
    assign rd_en     = CS & ~WE;
    assign wr_en     = CS & WE;
    // The middle address bits are deliberately ignored; RAM aliases across them.
    assign unused_addr = ^ADDR;

    // Data RAM. It has no reset, so its contents survive a reset.
    logic [31:0] mem [Depth];

    always_ff @(posedge CLK) begin
        if (wr_en && is_ram) begin
            mem[ram_idx] <= Data_BUS_WRITE;
        end
    end

    // GPIO and synchronizer
    logic [GPIO_W-1:0] gpio_out_q;
    logic [GPIO_W-1:0] sync1_q;
    logic [GPIO_W-1:0] sync2_q;
    logic              gpio_we;

    assign gpio_we  = wr_en & is_periph & (offset == OffGpioOut);
    assign gpio_out = gpio_out_q;

`ifdef DATA_BUS_TIMER_EN
    // Timer
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cmp_q, cmp_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        flag_q, flag_d;
    logic        tmr_match;
    logic        cnt_we, cmp_we, ctrl_we, stat_we;

    assign cnt_we    = wr_en & is_periph & (offset == OffTmrCnt);
    assign cmp_we    = wr_en & is_periph & (offset == OffTmrCmp);
    assign ctrl_we   = wr_en & is_periph & (offset == OffTmrCtrl);
    assign stat_we   = wr_en & is_periph & (offset == OffTmrStat);
    assign tmr_match = ctrl_q[0] & (cnt_q == cmp_q);

    always_comb begin
        cnt_d  = cnt_q;
        cmp_d  = cmp_q;
        ctrl_d = ctrl_q;
        flag_d = flag_q;
        // A match wins over a coincident write-1-clear.
        if (tmr_match) begin
            flag_d = 1'b1;
        end else if (stat_we && Data_BUS_WRITE[0]) begin
            flag_d = 1'b0;
        end
        // A cpu write to CNT overrides both increment and reload.
        if (cnt_we) begin
            cnt_d = Data_BUS_WRITE;
        end else if (ctrl_q[0]) begin
            cnt_d = (tmr_match && ctrl_q[1]) ? 32'd0 : cnt_q + 32'd1;
        end
        if (cmp_we) begin
            cmp_d = Data_BUS_WRITE;
        end
        if (ctrl_we) begin
            ctrl_d = Data_BUS_WRITE[2:0];
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt_q  <= 32'd0;
            cmp_q  <= 32'd0;
            ctrl_q <= 3'd0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cmp_q  <= cmp_d;
            ctrl_q <= ctrl_d;
            flag_q <= flag_d;
        end
    end

    assign irq = flag_q & ctrl_q[2];
`else
    assign irq = 1'b0;
`endif

    // Read mux and unmapped detection
    logic [31:0] rd_data;
    logic        unmapped;

    always_comb begin
        rd_data  = UnmappedData;
        unmapped = 1'b1;
        if (is_ram) begin
            rd_data  = mem[ram_idx];
            unmapped = 1'b0;
        end else if (is_periph) begin
            unique case (offset)
                OffGpioOut: begin
                    rd_data  = 32'(gpio_out_q);
                    unmapped = 1'b0;
                end
                OffGpioIn: begin
                    rd_data  = 32'(sync2_q);
                    unmapped = 1'b0;
                end
`ifdef DATA_BUS_TIMER_EN
                OffTmrCnt: begin
                    rd_data  = cnt_q;
                    unmapped = 1'b0;
                end
                OffTmrCmp: begin
                    rd_data  = cmp_q;
                    unmapped = 1'b0;
                end
                OffTmrCtrl: begin
                    rd_data  = 32'(ctrl_q);
                    unmapped = 1'b0;
                end
                OffTmrStat: begin
                    rd_data  = 32'(flag_q);
                    unmapped = 1'b0;
                end
`endif
                default: begin
                    rd_data  = UnmappedData;
                    unmapped = 1'b1;
                end
            endcase
        end
    end

    // Bus-facing registers
    logic [31:0] rdata_q;
    logic        bus_err_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rdata_q    <= 32'd0;
            bus_err_q  <= 1'b0;
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            if (rd_en) begin
                rdata_q <= rd_data;
            end
            bus_err_q <= CS & unmapped;
            if (gpio_we) begin
                gpio_out_q <= Data_BUS_WRITE[GPIO_W-1:0];
            end
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
        end
    end

    assign Data_BUS_READ = rdata_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed self-checking bench for data_bus_ctrl (DEPTH_LOG2=10, GPIO_W=8).
// Timer checks follow DATA_BUS_TIMER_EN; without it, the bench checks that the
// timer offsets decode as unmapped.

module tb_data_bus_ctrl;

    logic        CLK;
    logic        reset;
    logic        CS;
    logic        WE;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq;
    logic        bus_err;

    int unsigned chk_count;
    int unsigned err_count;
    logic [31:0] rd;
    logic        err;

    data_bus_ctrl #(
        .DEPTH_LOG2 (10),
        .GPIO_W     (8)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .CS             (CS),
        .WE             (WE),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .Data_BUS_READ  (Data_BUS_READ),
        .gpio_in        (gpio_in),
        .gpio_out       (gpio_out),
        .irq            (irq),
        .bus_err        (bus_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Both tasks are entered at a negedge and return at the negedge after the
    // sampling edge, where the read data and bus_err are observable.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic e);
        CS = 1'b1;
        WE = 1'b1;
        ADDR = a;
        Data_BUS_WRITE = d;
        @(negedge CLK);
        CS = 1'b0;
        WE = 1'b0;
        e = bus_err;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        CS = 1'b1;
        WE = 1'b0;
        ADDR = a;
        @(negedge CLK);
        CS = 1'b0;
        d = Data_BUS_READ;
        e = bus_err;
    endtask

    initial begin
        chk_count = 0;
        err_count = 0;
        reset = 1'b1;
        CS = 1'b0;
        WE = 1'b0;
        ADDR = 32'd0;
        Data_BUS_WRITE = 32'd0;
        gpio_in = 8'h00;
        #3;
        check("rst_rdata", Data_BUS_READ, 32'd0);
        check("rst_err", {31'd0, bus_err}, 32'd0);
        check("rst_gpio", {24'd0, gpio_out}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;

        // RAM, including aliasing and the top index
        bus_write(32'h0000_0010, 32'h1234_5678, err);
        check("ram_wr_err", {31'd0, err}, 32'd0);
        bus_read(32'h0000_0010, rd, err);
        check("ram_rd", rd, 32'h1234_5678);
        check("ram_rd_err", {31'd0, err}, 32'd0);
        bus_read(32'h0000_0410, rd, err);
        check("ram_alias", rd, 32'h1234_5678);
        bus_write(32'h0000_03FF, 32'hCAFE_F00D, err);
        bus_read(32'h0000_03FF, rd, err);
        check("ram_top", rd, 32'hCAFE_F00D);
        bus_write(32'h0000_0011, 32'h0BAD_0001, err);
        check("hold_on_write", Data_BUS_READ, 32'hCAFE_F00D);
        bus_read(32'h0000_0010, rd, err);
        check("ram_neighbor", rd, 32'h1234_5678);

        // GPIO
        bus_write(32'hF000_0000, 32'hFFFF_FFA5, err);
        check("gpio_out", {24'd0, gpio_out}, 32'h0000_00A5);
        bus_read(32'hF000_0000, rd, err);
        check("gpio_out_rd", rd, 32'h0000_00A5);
        bus_write(32'hF000_0001, 32'h0000_0011, err);
        check("gpio_in_wr_err", {31'd0, err}, 32'd0);
        check("gpio_in_wr_keep", {24'd0, gpio_out}, 32'h0000_00A5);
        gpio_in = 8'h3C;
        bus_read(32'hF000_0001, rd, err);
        check("sync_lat1", rd, 32'd0);
        bus_read(32'hF000_0001, rd, err);
        check("sync_lat2", rd, 32'd0);
        bus_read(32'hF000_0001, rd, err);
        check("gpio_in_rd", rd, 32'h0000_003C);

        // Unmapped
        bus_read(32'h8000_0000, rd, err);
        check("unm_rd", rd, 32'hDEAD_BEEF);
        check("unm_rd_err", {31'd0, err}, 32'd1);
        @(negedge CLK);
        check("unm_idle_rd", Data_BUS_READ, 32'hDEAD_BEEF);
        check("unm_idle_err", {31'd0, bus_err}, 32'd0);
        bus_write(32'h1234_0000, 32'h5555_5555, err);
        check("unm_wr_err", {31'd0, err}, 32'd1);
        check("unm_wr_hold", Data_BUS_READ, 32'hDEAD_BEEF);
        bus_read(32'hF000_0006, rd, err);
        check("off6_rd", rd, 32'hDEAD_BEEF);
        check("off6_err", {31'd0, err}, 32'd1);

`ifdef DATA_BUS_TIMER_EN
        begin
            logic [31:0] seq [6];
            seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
            bus_write(32'hF000_0003, 32'd4, err);
            bus_write(32'hF000_0004, 32'd7, err);
            for (int i = 0; i < 6; i++) begin
                bus_read(32'hF000_0002, rd, err);
                check($sformatf("cnt_seq%0d", i), rd, seq[i]);
                if (i == 3) check("irq_before", {31'd0, irq}, 32'd0);
                if (i == 4) check("irq_after_match", {31'd0, irq}, 32'd1);
            end
        end
        bus_read(32'hF000_0005, rd, err);
        check("stat_set", rd, 32'd1);
        bus_write(32'hF000_0005, 32'd1, err);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        // The counter now holds 3; the idle edge takes it to 4, and the CNT
        // write lands on the match edge.
        @(negedge CLK);
        bus_write(32'hF000_0002, 32'h0000_0100, err);
        bus_read(32'hF000_0002, rd, err);
        check("cnt_wr_wins", rd, 32'h0000_0100);
        bus_read(32'hF000_0005, rd, err);
        check("flag_on_coll", rd, 32'd1);
        bus_write(32'hF000_0002, 32'd3, err);
        @(negedge CLK);
        bus_write(32'hF000_0005, 32'd1, err);
        bus_read(32'hF000_0005, rd, err);
        check("match_beats_clr", rd, 32'd1);
        // Without auto-reload the counter runs past CMP.
        bus_write(32'hF000_0004, 32'd1, err);
        bus_write(32'hF000_0005, 32'd1, err);
        bus_write(32'hF000_0002, 32'd3, err);
        bus_read(32'hF000_0002, rd, err);
        check("noreload3", rd, 32'd3);
        bus_read(32'hF000_0002, rd, err);
        check("noreload4", rd, 32'd4);
        bus_read(32'hF000_0002, rd, err);
        check("noreload5", rd, 32'd5);
        bus_read(32'hF000_0005, rd, err);
        check("noreload_flag", rd, 32'd1);
        check("irq_masked", {31'd0, irq}, 32'd0);
        bus_write(32'hF000_0002, 32'hFFFF_FFFF, err);
        bus_read(32'hF000_0002, rd, err);
        check("wrap_max", rd, 32'hFFFF_FFFF);
        bus_read(32'hF000_0002, rd, err);
        check("wrap_zero", rd, 32'd0);
`else
        for (int i = 2; i < 6; i++) begin
            bus_read(32'hF000_0000 + 32'(i), rd, err);
            check($sformatf("notmr_rd%0d", i), rd, 32'hDEAD_BEEF);
            check($sformatf("notmr_err%0d", i), {31'd0, err}, 32'd1);
        end
        bus_write(32'hF000_0004, 32'd7, err);
        check("notmr_wr_err", {31'd0, err}, 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        check("notmr_irq", {31'd0, irq}, 32'd0);
`endif

        // Reset in the middle of a GPIO_OUT read
        bus_read(32'h0000_0010, rd, err);
        CS = 1'b1;
        WE = 1'b0;
        ADDR = 32'hF000_0000;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_rdata", Data_BUS_READ, 32'd0);
        check("mid_rst_gpio", {24'd0, gpio_out}, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        check("mid_rst_err", {31'd0, bus_err}, 32'd0);
        @(negedge CLK);
        CS = 1'b0;
        reset = 1'b0;
        bus_read(32'h0000_0010, rd, err);
        check("ram_after_rst", rd, 32'h1234_5678);
`ifdef DATA_BUS_TIMER_EN
        bus_read(32'hF000_0002, rd, err);
        check("cnt_after_rst", rd, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", chk_count, err_count);
        $finish;
    end

endmodule
